// File: rtl/memory_island_port_mux.sv
// memory_island_port_mux
// Merges NumIn memory-style requestor ports onto a single memory_island_core
// port. Two-class round-robin arbitration with a low-class anti-starvation
// override, and a fixed-latency response path routed by a source-ID delay line.
// Optional per-port performance counters: define MEMORY_ISLAND_PORT_MUX_PERF_EN.

`ifndef SYNTHESIS
module memory_island_port_mux_chk (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic out_rvalid_i,
    input  logic tail_valid_i
);
    // An island response must coincide exactly with a valid delay-line tail.
    a_rsp_align : assert property (@(posedge clk_i) disable iff (!rst_ni)
        out_rvalid_i == tail_valid_i);
endmodule
`endif

module memory_island_port_mux #(
    parameter int unsigned       NumIn         = 2,
    parameter int unsigned       AddrWidth     = 32,
    parameter int unsigned       DataWidth     = 64,
    parameter int unsigned       MemRspLatency = 1,
    parameter logic [NumIn-1:0]  PrioIn        = '0,
    parameter int unsigned       PrioWait      = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [NumIn-1:0]             in_req_i,
    output logic [NumIn-1:0]             in_gnt_o,
    input  logic [NumIn*AddrWidth-1:0]   in_addr_i,
    input  logic [NumIn-1:0]             in_we_i,
    input  logic [NumIn*DataWidth-1:0]   in_wdata_i,
    input  logic [NumIn*DataWidth/8-1:0] in_strb_i,
    output logic [NumIn-1:0]             in_rvalid_o,
    output logic [NumIn*DataWidth-1:0]   in_rdata_o,
    output logic                         out_req_o,
    input  logic                         out_gnt_i,
    output logic [AddrWidth-1:0]         out_addr_o,
    output logic                         out_we_o,
    output logic [DataWidth-1:0]         out_wdata_o,
    output logic [DataWidth/8-1:0]       out_strb_o,
    input  logic                         out_rvalid_i,
    input  logic [DataWidth-1:0]         out_rdata_i,
    output logic [NumIn*32-1:0]          perf_gnt_o,
    output logic [NumIn*32-1:0]          perf_stall_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned IdWidth   = (NumIn > 1) ? $clog2(NumIn) : 1;
    localparam int unsigned WaitWidth = (PrioWait > 0) ? $clog2(PrioWait + 1) : 1;
    localparam int unsigned DlIdWidth = MemRspLatency * IdWidth;

    // First requester at or after ptr, wrapping modulo NumIn.
    function automatic logic [IdWidth-1:0] rr_pick(input logic [NumIn-1:0] mask,
                                                   input logic [IdWidth-1:0] ptr);
        logic [IdWidth-1:0] pick;
        logic               found;
        int                 idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < int'(NumIn); i++) begin
            idx = int'(ptr) + i;
            if (idx >= int'(NumIn)) idx = idx - int'(NumIn);
            if (!found && mask[IdWidth'(idx)]) begin
                pick  = IdWidth'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Saturating 32-bit increment; counters stick at all-ones.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [IdWidth-1:0]   r_ptr_hi;
    logic [IdWidth-1:0]   r_ptr_lo;
    logic [WaitWidth-1:0] r_wait;
    logic [MemRspLatency-1:0] r_dl_valid;
    logic [DlIdWidth-1:0]     r_dl_id;

    logic [NumIn-1:0]   w_hi_mask;
    logic [NumIn-1:0]   w_hi_req;
    logic [NumIn-1:0]   w_lo_req;
    logic               w_any_hi;
    logic               w_any_lo;
    logic               w_override;
    logic               w_win_low;
    logic [IdWidth-1:0] w_winner;
    logic [IdWidth-1:0] w_win_nxt;
    logic               w_hs;
    logic [NumIn-1:0]   w_sel;
    logic               w_tail_valid;
    logic [IdWidth-1:0] w_tail_id;

    logic [AddrWidth-1:0] w_addr_m  [NumIn];
    logic                 w_we_m    [NumIn];
    logic [DataWidth-1:0] w_wdata_m [NumIn];
    logic [StrbWidth-1:0] w_strb_m  [NumIn];

    // A single port has no classes: everything is treated as low class.
    assign w_hi_mask  = (NumIn == 1) ? '0 : PrioIn;
    assign w_hi_req   = in_req_i & w_hi_mask;
    assign w_lo_req   = in_req_i & ~w_hi_mask;
    assign w_any_hi   = |w_hi_req;
    assign w_any_lo   = |w_lo_req;
    assign w_override = (PrioWait != 32'd0) && (r_wait >= WaitWidth'(PrioWait)) && w_any_lo;
    assign w_win_low  = w_override || !w_any_hi;
    assign w_winner   = w_win_low ? rr_pick(w_lo_req, r_ptr_lo) : rr_pick(w_hi_req, r_ptr_hi);
    assign w_win_nxt  = (w_winner == IdWidth'(NumIn - 1)) ? '0 : w_winner + IdWidth'(1);

    assign out_req_o  = |in_req_i;
    assign w_hs       = out_req_o & out_gnt_i;

    assign w_tail_valid = r_dl_valid[MemRspLatency-1];
    assign w_tail_id    = r_dl_id[DlIdWidth-1 -: IdWidth];
    assign in_rdata_o   = {NumIn{out_rdata_i}};

    for (genvar p = 0; p < NumIn; p++) begin : g_port
        assign w_sel[p]       = (w_winner == IdWidth'(p));
        assign in_gnt_o[p]    = w_hs & w_sel[p];
        assign in_rvalid_o[p] = out_rvalid_i & w_tail_valid & (w_tail_id == IdWidth'(p));
        assign w_addr_m[p]    = w_sel[p] ? in_addr_i[p*AddrWidth +: AddrWidth] : '0;
        assign w_we_m[p]      = w_sel[p] & in_we_i[p];
        assign w_wdata_m[p]   = w_sel[p] ? in_wdata_i[p*DataWidth +: DataWidth] : '0;
        assign w_strb_m[p]    = w_sel[p] ? in_strb_i[p*StrbWidth +: StrbWidth] : '0;
`ifdef MEMORY_ISLAND_PORT_MUX_PERF_EN
        logic [31:0] r_perf_gnt;
        logic [31:0] r_perf_stall;
        // Per-port saturating counts of grants and of stalled request cycles.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_perf_gnt   <= 32'd0;
                r_perf_stall <= 32'd0;
            end else begin
                if (in_gnt_o[p]) r_perf_gnt <= sat_inc(r_perf_gnt);
                else             r_perf_gnt <= r_perf_gnt;
                if (in_req_i[p] && !in_gnt_o[p]) r_perf_stall <= sat_inc(r_perf_stall);
                else                             r_perf_stall <= r_perf_stall;
            end
        end
        assign perf_gnt_o[p*32 +: 32]   = r_perf_gnt;
        assign perf_stall_o[p*32 +: 32] = r_perf_stall;
`else
        assign perf_gnt_o[p*32 +: 32]   = 32'd0;
        assign perf_stall_o[p*32 +: 32] = 32'd0;
`endif
    end

    // Payload mux: OR of the one-hot masked port fields.
    always_comb begin
        out_addr_o  = '0;
        out_we_o    = 1'b0;
        out_wdata_o = '0;
        out_strb_o  = '0;
        for (int p = 0; p < int'(NumIn); p++) begin
            out_addr_o  = out_addr_o  | w_addr_m[p];
            out_we_o    = out_we_o    | w_we_m[p];
            out_wdata_o = out_wdata_o | w_wdata_m[p];
            out_strb_o  = out_strb_o  | w_strb_m[p];
        end
    end

    // Round-robin pointers per class and the low-class starvation counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr_hi <= '0;
            r_ptr_lo <= '0;
            r_wait   <= '0;
        end else begin
            if (w_hs) begin
                if (w_win_low) r_ptr_lo <= w_win_nxt;
                else           r_ptr_hi <= w_win_nxt;
            end else begin
                r_ptr_hi <= r_ptr_hi;
                r_ptr_lo <= r_ptr_lo;
            end
            if (!w_any_lo)                              r_wait <= '0;
            else if (w_hs && w_win_low)                 r_wait <= '0;
            else if (r_wait < WaitWidth'(PrioWait))     r_wait <= r_wait + WaitWidth'(1);
            else                                        r_wait <= r_wait;
        end
    end

    // Source-ID delay line: a new {valid,id} enters each cycle, oldest at the top.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_dl_valid <= '0;
            r_dl_id    <= '0;
        end else begin
            r_dl_valid <= (r_dl_valid << 1) | MemRspLatency'(w_hs);
            r_dl_id    <= (r_dl_id << IdWidth) | DlIdWidth'(w_winner);
        end
    end

`ifndef SYNTHESIS
    memory_island_port_mux_chk u_chk (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .out_rvalid_i (out_rvalid_i),
        .tail_valid_i (w_tail_valid)
    );
`endif

endmodule
